// File: rtl/aes_seq_pkg.sv
// Shared types, constants and the AES S-box for the iterative AES-128 round sequencer.
package aes_seq_pkg;
   localparam int BLOCK_W = 128;

   typedef logic [3:0] round_t;
   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

   localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   // Entry 0 sits in the most significant byte.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[x];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Round 0 / idle have no Rcon; return zero rather than index outside the table.
   function automatic logic [7:0] rcon_of(input round_t r);
      if (r >= 4'd1 && r <= 4'd10)
         return RCON[r];
      return 8'h00;
   endfunction
endpackage

// File: rtl/aes_key_step.sv
// One step of the AES-128 key schedule: derives the next round key from the current one.
module aes_key_step import aes_seq_pkg::*; (
   input  logic [BLOCK_W-1:0] key_i,
   input  logic [7:0]         rcon_i,
   output logic [BLOCK_W-1:0] key_o
);
   logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;

   assign {w0, w1, w2, w3} = key_i;
   // SubWord(RotWord(w3)) with Rcon folded into the top byte
   assign t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
               ^ {rcon_i, 24'h000000};
   assign n0 = w0 ^ t;
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;
   assign key_o = {n0, n1, n2, n3};
endmodule

// File: rtl/aes_round_ops.sv
// Combinational AES round primitives: SubBytes, ShiftRows, MixColumns, AddRoundKey.
// Byte i of a block is [127-8i -: 8], laid out column-major (row i%4, column i/4).
module aes_sub_bytes import aes_seq_pkg::*; (
   input  logic [BLOCK_W-1:0] in_i,
   output logic [BLOCK_W-1:0] out_o
);
   for (genvar gi = 0; gi < 16; gi++) begin : g_byte
      assign out_o[127-8*gi -: 8] = sbox(in_i[127-8*gi -: 8]);
   end
endmodule

module aes_shift_rows import aes_seq_pkg::*; (
   input  logic [BLOCK_W-1:0] in_i,
   output logic [BLOCK_W-1:0] out_o
);
   for (genvar gi = 0; gi < 16; gi++) begin : g_byte
      localparam int SRC = 4 * (((gi / 4) + (gi % 4)) % 4) + (gi % 4);
      assign out_o[127-8*gi -: 8] = in_i[127-8*SRC -: 8];
   end
endmodule

module aes_mix_columns import aes_seq_pkg::*; (
   input  logic [BLOCK_W-1:0] in_i,
   output logic [BLOCK_W-1:0] out_o
);
   for (genvar gi = 0; gi < 4; gi++) begin : g_col
      logic [7:0] a0, a1, a2, a3;
      assign {a0, a1, a2, a3} = in_i[127-32*gi -: 32];
      assign out_o[127-32*gi -: 32] = {
         xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
         a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
         a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
         xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   end
endmodule

module aes_add_round_key import aes_seq_pkg::*; (
   input  logic [BLOCK_W-1:0] state_i,
   input  logic [BLOCK_W-1:0] key_i,
   output logic [BLOCK_W-1:0] out_o
);
   assign out_o = state_i ^ key_i;
endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryptor: one shared round datapath, one round per clock,
// on-the-fly key schedule, valid/ready on both input and output.
module aes_round_sequencer import aes_seq_pkg::*; #(
   parameter int ROUNDS = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [BLOCK_W-1:0] in_key,
   input  logic [BLOCK_W-1:0] in_msg,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [BLOCK_W-1:0] out_ct,
   output logic [BLOCK_W-1:0] out_key,
   output logic               busy,
   output logic [3:0]         round
);
   localparam round_t LAST = round_t'(ROUNDS);

   state_t             state_q, state_d;
   logic [BLOCK_W-1:0] blk_q, blk_d;
   logic [BLOCK_W-1:0] key_q, key_d;
   round_t             rnd_q, rnd_d;

   logic [BLOCK_W-1:0] nk, sb, sr, mc, mixed, round_out;

   aes_key_step      u_key (.key_i(key_q), .rcon_i(rcon_of(rnd_q)), .key_o(nk));
   aes_sub_bytes     u_sb  (.in_i(blk_q), .out_o(sb));
   aes_shift_rows    u_sr  (.in_i(sb), .out_o(sr));
   aes_mix_columns   u_mc  (.in_i(sr), .out_o(mc));
   // Final round skips MixColumns
   assign mixed = (rnd_q == LAST) ? sr : mc;
   aes_add_round_key u_ark (.state_i(mixed), .key_i(nk), .out_o(round_out));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         blk_q   <= '0;
         key_q   <= '0;
         rnd_q   <= '0;
      end else begin
         state_q <= state_d;
         blk_q   <= blk_d;
         key_q   <= key_d;
         rnd_q   <= rnd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      blk_d   = blk_q;
      key_d   = key_q;
      rnd_d   = rnd_q;
      unique case (state_q)
         IDLE: if (in_valid) begin
            blk_d   = in_msg ^ in_key;
            key_d   = in_key;
            rnd_d   = 4'd1;
            state_d = ROUND;
         end
         ROUND: begin
            blk_d = round_out;
            key_d = nk;
            if (rnd_q == LAST) state_d = DONE;
            else               rnd_d   = round_t'(rnd_q + 4'd1);
         end
         DONE: if (out_ready) begin
            state_d = IDLE;
            rnd_d   = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      busy      = (state_q == ROUND);
      out_valid = (state_q == DONE);
      out_ct    = out_valid ? blk_q : '0;
      out_key   = out_valid ? key_q : '0;
      round     = rnd_q;
   end
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench: FIPS-197 vectors, random jobs against a byte-level AES model,
// back-pressure, mid-operation reset and a reduced ROUNDS=1 instance.
module tb_aes_round_sequencer;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n, in_valid, out_ready, in_ready, out_valid, busy;
   logic [127:0] in_key, in_msg, out_ct, out_key;
   logic [3:0]   round;
   logic         d1_in_valid, d1_out_ready, d1_in_ready, d1_out_valid, d1_busy;
   logic [127:0] d1_in_key, d1_in_msg, d1_out_ct, d1_out_key;
   logic [3:0]   d1_round;

   aes_round_sequencer #(.ROUNDS(10)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_key(in_key), .in_msg(in_msg), .out_valid(out_valid), .out_ready(out_ready),
      .out_ct(out_ct), .out_key(out_key), .busy(busy), .round(round));

   aes_round_sequencer #(.ROUNDS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
      .in_key(d1_in_key), .in_msg(d1_in_msg), .out_valid(d1_out_valid),
      .out_ready(d1_out_ready), .out_ct(d1_out_ct), .out_key(d1_out_key),
      .busy(d1_busy), .round(d1_round));

   int n_cmp = 0;
   int n_bad = 0;
   int n_job = 0;
   logic [7:0] sbox_m [256];

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- reference model (GF arithmetic, FIPS-197 key expansion) ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a = a_in, b = b_in, p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         b = b >> 1;
         a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] d = {b, b};
      return d[15-n -: 8];
   endfunction

   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic aes_model(input logic [127:0] key, input logic [127:0] msg, input int nr,
                            output logic [127:0] ct, output logic [127:0] kout);
      logic [31:0] w [0:43];
      logic [31:0] temp;
      logic [7:0]  st [4][4];
      logic [7:0]  tmp [4][4];
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 4*nr + 4; i++) begin
         temp = w[i-1];
         if (i % 4 == 0) begin
            temp = {sbox_m[temp[23:16]], sbox_m[temp[15:8]], sbox_m[temp[7:0]], sbox_m[temp[31:24]]}
                   ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ temp;
      end
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            st[r][c] = msg[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
      for (int rn = 1; rn <= nr; rn++) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) tmp[r][c] = sbox_m[st[r][(c+r)%4]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
               if (rn < nr)
                  st[r][c] = gmul(tmp[r][c], 8'h02) ^ gmul(tmp[(r+1)%4][c], 8'h03)
                             ^ tmp[(r+2)%4][c] ^ tmp[(r+3)%4][c];
               else
                  st[r][c] = tmp[r][c];
               st[r][c] = st[r][c] ^ w[4*rn+c][31-8*r -: 8];
            end
      end
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) ct[127-8*(4*c+r) -: 8] = st[r][c];
      kout = {w[4*nr], w[4*nr+1], w[4*nr+2], w[4*nr+3]};
   endtask

   // ---------------- one full job on the ROUNDS=10 instance ----------------
   task automatic run_job(input logic [127:0] key, input logic [127:0] msg, input int bp,
                          output logic [127:0] ct, output logic [127:0] kout);
      logic [127:0] ect, ek;
      aes_model(key, msg, 10, ect, ek);
      check_eq("in_ready_idle", 128'(in_ready), 128'(1));
      in_valid = 1'b1; in_key = key; in_msg = msg;
      @(posedge clk); #1;
      for (int c = 1; c <= 10; c++) begin
         check_eq("round_trace", 128'(round), 128'(c));
         check_eq("busy_round", 128'(busy), 128'(1));
         check_eq("in_ready_busy", 128'(in_ready), 128'(0));
         check_eq("out_valid_early", 128'(out_valid), 128'(0));
         in_valid  = 1'($urandom_range(0, 1));
         in_key    = {$urandom, $urandom, $urandom, $urandom};
         in_msg    = {$urandom, $urandom, $urandom, $urandom};
         out_ready = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      check_eq("out_valid_done", 128'(out_valid), 128'(1));
      check_eq("busy_done", 128'(busy), 128'(0));
      check_eq("round_done", 128'(round), 128'(10));
      check_eq("ct_model", out_ct, ect);
      check_eq("key_model", out_key, ek);
      ct = out_ct; kout = out_key;
      out_ready = 1'b0;
      for (int i = 0; i < bp; i++) begin
         in_valid = 1'b1;
         in_msg   = {$urandom, $urandom, $urandom, $urandom};
         @(posedge clk); #1;
         check_eq("bp_valid", 128'(out_valid), 128'(1));
         check_eq("bp_ct", out_ct, ect);
         check_eq("bp_key", out_key, ek);
         check_eq("bp_in_ready", 128'(in_ready), 128'(0));
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_eq("post_valid", 128'(out_valid), 128'(0));
      check_eq("post_in_ready", 128'(in_ready), 128'(1));
      check_eq("post_round", 128'(round), 128'(0));
      n_job++;
      $display("job %0d key=%h msg=%h ct=%h bp=%0d", n_job, key, msg, ct, bp);
   endtask

   initial begin
      logic [127:0] ct, kout, ect, ek, k, m;
      build_sbox();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_key = '0; in_msg = '0;
      d1_in_valid = 1'b0; d1_out_ready = 1'b0; d1_in_key = '0; d1_in_msg = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_in_ready", 128'(in_ready), 128'(1));
      check_eq("rst_out_valid", 128'(out_valid), 128'(0));
      check_eq("rst_out_ct", out_ct, 128'(0));
      check_eq("rst_out_key", out_key, 128'(0));
      check_eq("rst_busy", 128'(busy), 128'(0));
      check_eq("rst_round", 128'(round), 128'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;

      // FIPS-197 App. B with long back-pressure, then C.1 straight after
      run_job(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734, 20, ct, kout);
      check_eq("fips_b_ct", ct, 128'h3925841d02dc09fbdc118597196a0b32);
      check_eq("fips_b_key", kout, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      run_job(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff, 0, ct, kout);
      check_eq("fips_c1_ct", ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      check_eq("fips_c1_key", kout, 128'h13111d7fe3944a17f307a78b4d2b30c5);

      for (int j = 0; j < 6; j++) begin
         k = {$urandom, $urandom, $urandom, $urandom};
         m = {$urandom, $urandom, $urandom, $urandom};
         run_job(k, m, int'($urandom_range(0, 3)), ct, kout);
      end

      // Reset in the middle of round 5
      in_valid = 1'b1; in_key = {4{$urandom}}; in_msg = {4{$urandom}};
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      check_eq("mid_round5", 128'(round), 128'(5));
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check_eq("mid_rst_in_ready", 128'(in_ready), 128'(1));
      check_eq("mid_rst_valid", 128'(out_valid), 128'(0));
      check_eq("mid_rst_round", 128'(round), 128'(0));
      check_eq("mid_rst_busy", 128'(busy), 128'(0));
      run_job(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734, 1, ct, kout);
      check_eq("after_rst_ct", ct, 128'h3925841d02dc09fbdc118597196a0b32);

      // ROUNDS=1 instance: round 0 plus final round only
      k = 128'h000102030405060708090a0b0c0d0e0f;
      m = 128'h00112233445566778899aabbccddeeff;
      aes_model(k, m, 1, ect, ek);
      check_eq("r1_in_ready", 128'(d1_in_ready), 128'(1));
      d1_in_valid = 1'b1; d1_in_key = k; d1_in_msg = m;
      @(posedge clk); #1;
      d1_in_valid = 1'b0;
      check_eq("r1_round", 128'(d1_round), 128'(1));
      check_eq("r1_busy", 128'(d1_busy), 128'(1));
      check_eq("r1_valid_early", 128'(d1_out_valid), 128'(0));
      @(posedge clk); #1;
      check_eq("r1_valid", 128'(d1_out_valid), 128'(1));
      check_eq("r1_ct", d1_out_ct, ect);
      check_eq("r1_key", d1_out_key, ek);
      d1_out_ready = 1'b1;
      @(posedge clk); #1;
      d1_out_ready = 1'b0;
      check_eq("r1_post_valid", 128'(d1_out_valid), 128'(0));
      $display("job r1 key=%h msg=%h ct=%h", k, m, d1_out_ct);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
